v_sync_fsm: RTL and testbench

- Vertical timing stage directly downstream of the horizontal sync counter in the Breakout VGA path.
- Advances one line per horizontal end-of-line event (tick AND h_tick) through a 4-state vertical FSM: ACTIVE, FRONT, SYNC, BACK.
- Produces v_sync, v_video, the vertical line count, an end-of-frame tick, a one-clock frame_start strobe and the combined video_on used by the pixel generator.

---
 rtl/v_sync_fsm_if.sv | 24 ++
 rtl/v_sync_fsm.sv | 120 ++++++++++++
 tb/tb_v_sync_fsm.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/v_sync_fsm_if.sv
// Bundle between the horizontal sync stage, the vertical timing stage and the pixel generator.
// The vertical timing stage is the slave; the H_Sync/pixel side is the master.
interface v_sync_fsm_if;
  logic        tick;
  logic        h_tick;
  logic        h_video;
  logic        v_sync;
  logic        v_video;
  logic        video_on;
  logic        v_tick;
  logic        frame_start;
  logic [9:0]  q;
  logic [15:0] frame_cnt;

  modport slave (
    input  tick, h_tick, h_video,
    output v_sync, v_video, video_on, v_tick, frame_start, q, frame_cnt
  );

  modport master (
    output tick, h_tick, h_video,
    input  v_sync, v_video, video_on, v_tick, frame_start, q, frame_cnt
  );
endinterface

// File: rtl/v_sync_fsm.sv
// Vertical VGA timing: advances one line per pixel-enabled end-of-line through ACTIVE/FRONT/SYNC/BACK.
// Optional 16-bit completed-frame counter is built only when FRAME_CNT_EN is defined.
module v_sync_fsm #(
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic           clk,
  input  logic           reset,
  v_sync_fsm_if.slave    bus
);

  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] LAST_ACTIVE = 10'(V_ACTIVE - 1);
  localparam logic [9:0] LAST_FP     = 10'(V_FP - 1);
  localparam logic [9:0] LAST_SYNC   = 10'(V_SYNC - 1);
  localparam logic [9:0] LAST_BP     = 10'(V_BP - 1);
  localparam logic [9:0] LAST_LINE   = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    StActive = 2'b00,
    StFront  = 2'b01,
    StSync   = 2'b10,
    StBack   = 2'b11
  } state_e;

  state_e     r_state, w_state_d;
  logic [9:0] r_lc, w_lc_d;
  logic [9:0] r_q, w_q_d;
  logic       r_frame_start, w_frame_start_d;
  logic       w_line_adv;
  logic       w_lc_last;
  logic       w_illegal;

  assign w_line_adv = bus.tick & bus.h_tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= StActive;
      r_lc          <= '0;
      r_q           <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_lc          <= w_lc_d;
      r_q           <= w_q_d;
      r_frame_start <= w_frame_start_d;
    end
  end

  always_comb begin
    w_state_d       = r_state;
    w_lc_d          = r_lc;
    w_q_d           = r_q;
    w_frame_start_d = 1'b0;
    w_lc_last       = 1'b0;
    w_illegal       = 1'b0;

    case (r_state)
      StActive: w_lc_last = (r_lc == LAST_ACTIVE);
      StFront:  w_lc_last = (r_lc == LAST_FP);
      StSync:   w_lc_last = (r_lc == LAST_SYNC);
      StBack:   w_lc_last = (r_lc == LAST_BP);
      default:  w_illegal = 1'b1;
    endcase

    // Every 2-bit code is a named state; this path only guards against upsets.
    if (w_illegal) begin
      w_state_d = StActive;
      w_lc_d    = '0;
      w_q_d     = '0;
    end else if (w_line_adv) begin
      if (w_lc_last) begin
        w_lc_d = '0;
        case (r_state)
          StActive: w_state_d = StFront;
          StFront:  w_state_d = StSync;
          StSync:   w_state_d = StBack;
          default:  w_state_d = StActive;
        endcase
      end else begin
        w_lc_d = r_lc + 10'd1;
      end

      if (r_q == LAST_LINE) begin
        w_q_d           = '0;
        w_frame_start_d = 1'b1;
      end else begin
        w_q_d = r_q + 10'd1;
      end
    end
  end

  assign bus.v_video     = (r_state == StActive);
  assign bus.v_sync      = ~(r_state == StSync);
  assign bus.v_tick      = (r_q == LAST_LINE);
  assign bus.video_on    = bus.h_video & bus.v_video;
  assign bus.frame_start = r_frame_start;
  assign bus.q           = r_q;

`ifdef FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Counts on the same edge that raises frame_start, so both change together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_cnt <= '0;
    end else if (w_frame_start_d) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign bus.frame_cnt = r_frame_cnt;
`else
  assign bus.frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_v_sync_fsm.sv
// Scoreboard bench for v_sync_fsm: the driver pushes per-cycle expectations from a line-count model,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_v_sync_fsm;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  v_sync_fsm_if bus ();

  v_sync_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    logic [9:0]  q;
    logic        vs;
    logic        vv;
    logic        von;
    logic        vt;
    logic        fs;
    logic [15:0] fc;
    string       tag;
  } exp_t;

  exp_t sb[$];

  int          cycle = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          m_q = 0;
  logic        m_fs = 1'b0;
  logic [15:0] m_fc = 16'h0000;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic push(input string tag);
    exp_t e;
    e.cyc = cycle;
    e.q   = 10'(m_q);
    e.vv  = (m_q < 480);
    e.vs  = !(m_q == 490 || m_q == 491);
    e.von = bus.h_video && e.vv;
    e.vt  = (m_q == 524);
    e.fs  = m_fs;
    e.fc  = m_fc;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    m_q  = 0;
    m_fs = 1'b0;
    m_fc = 16'h0000;
  endtask

  // One clock: drive inputs, let the edge consume them, predict and queue the result.
  task automatic step(input logic t, input logic h, input logic hv, input string tag);
    bus.tick    = t;
    bus.h_tick  = h;
    bus.h_video = hv;
    @(posedge clk);
    #1;
    if (!reset) begin
      model_reset();
    end else begin
      m_fs = t && h && (m_q == 524);
      if (t && h) m_q = (m_q == 524) ? 0 : m_q + 1;
`ifdef FRAME_CNT_EN
      if (m_fs) m_fc = m_fc + 16'd1;
`endif
    end
    push(tag);
    @(negedge clk);
    #1;
  endtask

  // Assert reset between edges so the check lands before any clock edge.
  task automatic async_reset();
    bus.tick   = 1'b0;
    bus.h_tick = 1'b0;
    @(posedge clk);
    #2;
    m_fs  = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    push("async_reset");
    @(negedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cycle) begin
        e = sb.pop_front();
        n_chk++;
        if (e.cyc != cycle) begin
          n_fail++;
          $display("FAIL %s: expectation for cycle %0d checked at cycle %0d", e.tag, e.cyc, cycle);
        end else if ({bus.q, bus.v_sync, bus.v_video, bus.video_on, bus.v_tick, bus.frame_start,
                      bus.frame_cnt} !== {e.q, e.vs, e.vv, e.von, e.vt, e.fs, e.fc}) begin
          n_fail++;
          $display("FAIL %s cyc=%0d: got q=%0d vs=%b vv=%b von=%b vt=%b fs=%b fc=%0d, required q=%0d vs=%b vv=%b von=%b vt=%b fs=%b fc=%0d",
                   e.tag, cycle, bus.q, bus.v_sync, bus.v_video, bus.video_on, bus.v_tick,
                   bus.frame_start, bus.frame_cnt, e.q, e.vs, e.vv, e.von, e.vt, e.fs, e.fc);
        end
      end
    end
  end

  initial begin
    bus.tick    = 1'b0;
    bus.h_tick  = 1'b0;
    bus.h_video = 1'b0;
    model_reset();

    // Reset held for 5 clocks, even with line advances offered.
    repeat (5) step(1'b1, 1'b1, 1'b1, "reset_hold");
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b1, "post_reset");

    // Gating: neither h_tick nor tick alone advances.
    repeat (4) step(1'b0, 1'b1, 1'b1, "h_tick_only");
    step(1'b1, 1'b0, 1'b1, "tick_only");
    step(1'b1, 1'b1, 1'b0, "line_adv");
    step(1'b0, 1'b0, 1'b0, "idle");

    // Through ACTIVE, then porches and sync with gaps between advances.
    while (m_q < 478) step(1'b1, 1'b1, 1'(m_q % 2), "run_active");
    while (m_q != 524) begin
      step(1'b1, 1'b0, 1'b1, "gap");
      step(1'b1, 1'b1, 1'b1, "blank_adv");
    end
    step(1'b0, 1'b0, 1'b1, "v_tick_hold");
    step(1'b1, 1'b1, 1'b1, "wrap");
    step(1'b0, 1'b0, 1'b1, "fs_clear");
    step(1'b0, 1'b0, 1'b0, "fs_stays_low");

    // Two more full frames at one line per clock.
    repeat (2 * 525) step(1'b1, 1'b1, 1'b1, "frames");
    step(1'b0, 1'b0, 1'b1, "after_frames");

    // Mid-frame reset at line 300.
    while (m_q != 300) step(1'b1, 1'b1, 1'b1, "to_300");
    async_reset();
    repeat (2) step(1'b1, 1'b1, 1'b1, "mid_reset_hold");
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b1, "restart_line0");
    step(1'b1, 1'b1, 1'b1, "restart_line1");
    step(1'b1, 1'b1, 1'b0, "restart_line2");

    repeat (3) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
